// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-stage burn sequencer for the launch-vehicle model.
// Walks NUM_STAGES burns: LOAD registers the burn's table entries, BURN
// releases the velocity integrator until ignition_end, SEP holds it in reset
// for SEP_CYCLES, and an optional COAST (per-burn cycle count) precedes the
// next LOAD. Abort and the optional burn watchdog latch FAULT until RESETB.
//
// Ports
//   CLK, RESETB         clock, asynchronous active-low reset
//   start               launch / relaunch request (sampled in IDLE and DONE)
//   abort               forces FAULT from LOAD/BURN/SEP/COAST/DONE
//   ignition_end        burn complete from the integrator
//   *_tbl               per-burn tables, entry i at [i*W +: W] (coast: CNT_W)
//   specific_impulse, initial_weight, propellant_weight, burntime
//                       registered parameters of the current burn
//   engine_resetb       active-low integrator reset (high only in BURN)
//   stage_idx, state    current burn index and FSM state
//   stage_done          one-cycle pulse per accepted ignition_end
//   mission_done, fault high in DONE / FAULT
module stage_sequencer #(
  parameter int NUM_STAGES   = 4,
  parameter int W            = 64,
  parameter int CNT_W        = 32,
  parameter int IDX_W        = 3,
  parameter int SEP_CYCLES   = 4,
  parameter int BURN_TIMEOUT = 0
) (
  input  logic                        CLK,
  input  logic                        RESETB,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        ignition_end,
  input  logic [NUM_STAGES*W-1:0]     isp_tbl,
  input  logic [NUM_STAGES*W-1:0]     init_wt_tbl,
  input  logic [NUM_STAGES*W-1:0]     prop_wt_tbl,
  input  logic [NUM_STAGES*W-1:0]     burn_tbl,
  input  logic [NUM_STAGES*CNT_W-1:0] coast_tbl,
  output logic [W-1:0]                specific_impulse,
  output logic [W-1:0]                initial_weight,
  output logic [W-1:0]                propellant_weight,
  output logic [W-1:0]                burntime,
  output logic                        engine_resetb,
  output logic [IDX_W-1:0]            stage_idx,
  output logic [2:0]                  state,
  output logic                        stage_done,
  output logic                        mission_done,
  output logic                        fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_BURN  = 3'd2,
    S_SEP   = 3'd3,
    S_COAST = 3'd4,
    S_DONE  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] SEP_LAST = CNT_W'(SEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(BURN_TIMEOUT - 1);
  localparam bit               WD_EN    = (BURN_TIMEOUT != 0);

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_up, cnt_dn, coast_next;
  logic [IDX_W-1:0] idx_nxt, idx_inc;
  logic             done_nxt;

  // Saturating counter steps
  assign cnt_up = (&cnt)        ? cnt : cnt + CNT_W'(1);
  assign cnt_dn = (cnt == '0)   ? cnt : cnt - CNT_W'(1);

  assign idx_inc    = stage_idx + IDX_W'(1);
  assign coast_next = coast_tbl[idx_inc*CNT_W +: CNT_W];

  always_comb begin
    nxt      = cur;
    cnt_nxt  = cnt;
    idx_nxt  = stage_idx;
    done_nxt = 1'b0;
    case (cur)
      S_IDLE: if (start) begin
        nxt     = S_LOAD;
        idx_nxt = '0;
      end
      S_LOAD: begin
        nxt     = S_BURN;
        cnt_nxt = '0;
      end
      S_BURN: begin
        // cnt==0 blanks a stale ignition_end left over from the previous burn
        if (ignition_end && cnt != '0) begin
          nxt      = S_SEP;
          cnt_nxt  = '0;
          done_nxt = 1'b1;
        end else if (WD_EN && cnt == WD_LAST) begin
          nxt = S_FAULT;
        end else begin
          cnt_nxt = cnt_up;
        end
      end
      S_SEP: begin
        if (cnt >= SEP_LAST) begin
          if (stage_idx >= LAST_IDX) begin
            nxt = S_DONE;
          end else begin
            idx_nxt = idx_inc;
            if (coast_next == '0) begin
              nxt = S_LOAD;
            end else begin
              nxt     = S_COAST;
              cnt_nxt = coast_next;
            end
          end
        end else begin
          cnt_nxt = cnt_up;
        end
      end
      S_COAST: begin
        // Loaded with N, leaves on the cycle it reads 1: exactly N cycles
        if (cnt <= CNT_W'(1)) nxt = S_LOAD;
        else                  cnt_nxt = cnt_dn;
      end
      S_DONE: if (start) begin
        nxt     = S_LOAD;
        idx_nxt = '0;
      end
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IDLE;
    endcase
    // abort overrides everything, including a same-cycle ignition_end
    if (abort && cur != S_IDLE && cur != S_FAULT) begin
      nxt      = S_FAULT;
      cnt_nxt  = cnt;
      idx_nxt  = stage_idx;
      done_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      cur               <= S_IDLE;
      cnt               <= '0;
      stage_idx         <= '0;
      stage_done        <= 1'b0;
      specific_impulse  <= '0;
      initial_weight    <= '0;
      propellant_weight <= '0;
      burntime          <= '0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_nxt;
      stage_idx  <= idx_nxt;
      stage_done <= done_nxt;
      // Load on entry to LOAD so parameters are settled a full cycle before
      // engine_resetb rises
      if (nxt == S_LOAD) begin
        specific_impulse  <= isp_tbl[idx_nxt*W +: W];
        initial_weight    <= init_wt_tbl[idx_nxt*W +: W];
        propellant_weight <= prop_wt_tbl[idx_nxt*W +: W];
        burntime          <= burn_tbl[idx_nxt*W +: W];
      end
    end
  end

  assign state         = cur;
  assign engine_resetb = (cur == S_BURN);
  assign mission_done  = (cur == S_DONE);
  assign fault         = (cur == S_FAULT);

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer: directed scenarios plus randomized missions.
// Expected phase lengths and parameter values come from the sequencing rules
// (LOAD 1 cycle, BURN until accepted ignition_end, SEP_CYCLES, COAST N).
module tb_stage_sequencer;
  localparam int NS = 4, W = 64, CW = 32, IW = 3, SEP = 4, BT = 50;

  logic CLK = 1'b0, RESETB = 1'b0, start = 1'b0, abort = 1'b0, ignition_end = 1'b0;
  logic [NS*W-1:0]  isp_tbl, init_wt_tbl, prop_wt_tbl, burn_tbl;
  logic [NS*CW-1:0] coast_tbl;
  logic [W-1:0]     specific_impulse, initial_weight, propellant_weight, burntime;
  logic             engine_resetb, stage_done, mission_done, fault;
  logic [IW-1:0]    stage_idx;
  logic [2:0]       state;

  logic [W-1:0]  isp_a[NS], iw_a[NS], pw_a[NS], bt_a[NS];
  logic [CW-1:0] coast_a[NS];

  for (genvar g = 0; g < NS; g++) begin : g_pack
    assign isp_tbl[g*W +: W]     = isp_a[g];
    assign init_wt_tbl[g*W +: W] = iw_a[g];
    assign prop_wt_tbl[g*W +: W] = pw_a[g];
    assign burn_tbl[g*W +: W]    = bt_a[g];
    assign coast_tbl[g*CW +: CW] = coast_a[g];
  end

  stage_sequencer #(
    .NUM_STAGES(NS), .W(W), .CNT_W(CW), .IDX_W(IW),
    .SEP_CYCLES(SEP), .BURN_TIMEOUT(BT)
  ) dut (
    .CLK(CLK), .RESETB(RESETB), .start(start), .abort(abort),
    .ignition_end(ignition_end),
    .isp_tbl(isp_tbl), .init_wt_tbl(init_wt_tbl), .prop_wt_tbl(prop_wt_tbl),
    .burn_tbl(burn_tbl), .coast_tbl(coast_tbl),
    .specific_impulse(specific_impulse), .initial_weight(initial_weight),
    .propellant_weight(propellant_weight), .burntime(burntime),
    .engine_resetb(engine_resetb), .stage_idx(stage_idx), .state(state),
    .stage_done(stage_done), .mission_done(mission_done), .fault(fault)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int sd_count = 0;

  always @(negedge CLK) if (stage_done === 1'b1) sd_count++;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    start = 0; abort = 0; ignition_end = 0;
    RESETB = 0;
    #3;
    RESETB = 1;
  endtask

  task automatic launch();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic set_nominal();
    isp_a   = '{64'd263, 64'd421, 64'd421, 64'd421};
    bt_a    = '{64'd168, 64'd360, 64'd165, 64'd335};
    iw_a    = '{64'd300000, 64'd90000, 64'd40000, 64'd15000};
    pw_a    = '{64'd200000, 64'd50000, 64'd22000, 64'd9000};
    coast_a = '{32'd0, 32'd0, 32'd0, 32'd20};
  endtask

  task automatic randomize_tables();
    for (int i = 0; i < NS; i++) begin
      isp_a[i]   = {$urandom, $urandom};
      iw_a[i]    = {$urandom, $urandom};
      pw_a[i]    = {$urandom, $urandom};
      bt_a[i]    = {$urandom, $urandom};
      coast_a[i] = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
    end
  endtask

  // Entry: in the LOAD cycle of burn i. ignition_end pulsed d BURN cycles in.
  // Exit: first cycle after SEP.
  task automatic do_burn(input int i, input int d);
    int n;
    bit early;
    checks++;
    if ({state, stage_idx, engine_resetb} !== {3'd1, 3'(i), 1'b0}) begin
      errors++;
      $display("FAIL load_state burn %0d got %0h exp %0h", i,
               {state, stage_idx, engine_resetb}, {3'd1, 3'(i), 1'b0});
    end
    checks++;
    if ({specific_impulse, initial_weight, propellant_weight, burntime} !==
        {isp_a[i], iw_a[i], pw_a[i], bt_a[i]}) begin
      errors++;
      $display("FAIL load_params burn %0d got %0h %0h %0h %0h exp %0h %0h %0h %0h", i,
               specific_impulse, initial_weight, propellant_weight, burntime,
               isp_a[i], iw_a[i], pw_a[i], bt_a[i]);
    end
    step();
    checks++;
    if ({state, engine_resetb} !== {3'd2, 1'b1}) begin
      errors++;
      $display("FAIL burn_entry burn %0d got %0h exp %0h", i, {state, engine_resetb}, 4'h5);
    end
    early = 0;
    repeat (d) begin
      step();
      if (state !== 3'd2 || stage_done !== 1'b0) early = 1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL burn_hold burn %0d left BURN before ignition_end exp 0 got 1", i);
    end
    ignition_end = 1;
    step();
    ignition_end = 0;
    checks++;
    if ({state, stage_done, engine_resetb} !== {3'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sep_entry burn %0d got %0h exp %0h", i,
               {state, stage_done, engine_resetb}, {3'd3, 1'b1, 1'b0});
    end
    n = 1;
    step();
    while (state === 3'd3 && n < 100) begin
      n++;
      step();
    end
    checks++;
    if (n != SEP) begin
      errors++;
      $display("FAIL sep_len burn %0d got %0d exp %0d", i, n, SEP);
    end
  endtask

  task automatic after_sep(input int i);
    int n;
    if (i == NS - 1) begin
      checks++;
      if ({state, mission_done, stage_idx} !== {3'd5, 1'b1, 3'(NS - 1)}) begin
        errors++;
        $display("FAIL done_state got %0h exp %0h", {state, mission_done, stage_idx},
                 {3'd5, 1'b1, 3'(NS - 1)});
      end
    end else if (coast_a[i+1] != 0) begin
      n = 0;
      while (state === 3'd4 && engine_resetb === 1'b0 && n < 1000) begin
        n++;
        step();
      end
      checks++;
      if (n != int'(coast_a[i+1])) begin
        errors++;
        $display("FAIL coast_len before burn %0d got %0d exp %0d", i + 1, n, coast_a[i+1]);
      end
    end
  endtask

  task automatic run_mission(input bit rnd);
    int sd0;
    sd0 = sd_count;
    for (int i = 0; i < NS; i++) begin
      do_burn(i, rnd ? $urandom_range(1, 15) : 10);
      after_sep(i);
    end
    checks++;
    if (sd_count - sd0 != NS) begin
      errors++;
      $display("FAIL stage_done_count got %0d exp %0d", sd_count - sd0, NS);
    end
  endtask

  task automatic test_reset();
    set_nominal();
    RESETB = 0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({specific_impulse, initial_weight, propellant_weight, burntime, engine_resetb,
         stage_idx, state, stage_done, mission_done, fault} !== '0) begin
      errors++;
      $display("FAIL reset_values got %0h exp 0", {specific_impulse, initial_weight,
               propellant_weight, burntime, engine_resetb, stage_idx, state, stage_done,
               mission_done, fault});
    end
    RESETB = 1;
  endtask

  task automatic test_abort_idle();
    abort = 1;
    repeat (3) step();
    abort = 0;
    checks++;
    if ({state, fault} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort_idle got %0h exp 0", {state, fault});
    end
  endtask

  task automatic test_nominal();
    set_nominal();
    launch();
    run_mission(1'b0);
  endtask

  task automatic test_restart();
    randomize_tables();
    start = 1;
    step();
    start = 0;
    checks++;
    if ({mission_done, state, stage_idx} !== {1'b0, 3'd1, 3'd0} ||
        initial_weight !== iw_a[0]) begin
      errors++;
      $display("FAIL restart got %0h iw %0h exp %0h iw %0h",
               {mission_done, state, stage_idx}, initial_weight, {1'b0, 3'd1, 3'd0}, iw_a[0]);
    end
    run_mission(1'b1);
  endtask

  task automatic test_back_to_back();
    repeat (3) begin
      randomize_tables();
      launch();
      run_mission(1'b1);
    end
  endtask

  task automatic test_blanking();
    do_reset();
    set_nominal();
    launch();
    ignition_end = 1;
    step();
    checks++;
    if ({state, stage_done} !== {3'd2, 1'b0}) begin
      errors++;
      $display("FAIL blank_c0 got %0h exp %0h", {state, stage_done}, {3'd2, 1'b0});
    end
    step();
    checks++;
    if ({state, stage_done} !== {3'd2, 1'b0}) begin
      errors++;
      $display("FAIL blank_c1 got %0h exp %0h", {state, stage_done}, {3'd2, 1'b0});
    end
    step();
    ignition_end = 0;
    checks++;
    if ({state, stage_done} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL blank_sep got %0h exp %0h", {state, stage_done}, {3'd3, 1'b1});
    end
  endtask

  task automatic test_watchdog();
    int n;
    do_reset();
    randomize_tables();
    launch();
    step();
    n = 0;
    while (state === 3'd2 && n < 200) begin
      n++;
      step();
    end
    checks++;
    if (n != BT) begin
      errors++;
      $display("FAIL wd_len got %0d exp %0d", n, BT);
    end
    checks++;
    if ({state, fault, engine_resetb} !== {3'd6, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wd_fault got %0h exp %0h", {state, fault, engine_resetb}, {3'd6, 1'b1, 1'b0});
    end
    start = 1;
    abort = 1;
    repeat (5) step();
    start = 0;
    abort = 0;
    checks++;
    if ({state, fault} !== {3'd6, 1'b1} || specific_impulse !== isp_a[0]) begin
      errors++;
      $display("FAIL fault_sticky got %0h isp %0h exp %0h isp %0h", {state, fault},
               specific_impulse, {3'd6, 1'b1}, isp_a[0]);
    end
  endtask

  task automatic test_abort();
    int sd0;
    do_reset();
    set_nominal();
    launch();
    repeat (3) step();
    sd0 = sd_count;
    abort = 1;
    ignition_end = 1;
    step();
    abort = 0;
    ignition_end = 0;
    step();
    checks++;
    if ({state, fault} !== {3'd6, 1'b1} || sd_count != sd0) begin
      errors++;
      $display("FAIL abort_prio got %0h pulses %0d exp %0h pulses 0", {state, fault},
               sd_count - sd0, {3'd6, 1'b1});
    end
  endtask

  task automatic test_reset_mid_coast();
    do_reset();
    set_nominal();
    launch();
    for (int i = 0; i < 3; i++) begin
      do_burn(i, 3);
      if (i < 2) after_sep(i);
    end
    checks++;
    if ({state, stage_idx} !== {3'd4, 3'd3}) begin
      errors++;
      $display("FAIL coast_reached got %0h exp %0h", {state, stage_idx}, {3'd4, 3'd3});
    end
    repeat (5) step();
    #2;
    RESETB = 0;
    #1;
    checks++;
    if ({specific_impulse, initial_weight, propellant_weight, burntime, engine_resetb,
         stage_idx, state, stage_done, mission_done, fault} !== '0) begin
      errors++;
      $display("FAIL async_reset got %0h exp 0", {specific_impulse, initial_weight,
               propellant_weight, burntime, engine_resetb, stage_idx, state, stage_done,
               mission_done, fault});
    end
    step();
    RESETB = 1;
    launch();
    checks++;
    if ({state, stage_idx} !== {3'd1, 3'd0} || specific_impulse !== 64'd263) begin
      errors++;
      $display("FAIL relaunch got %0h isp %0d exp %0h isp 263", {state, stage_idx},
               specific_impulse, {3'd1, 3'd0});
    end
  endtask

  initial begin
    test_reset();
    test_abort_idle();
    test_nominal();
    test_restart();
    test_back_to_back();
    test_blanking();
    test_watchdog();
    test_abort();
    test_reset_mid_coast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
